// File: rtl/cpu_multicycle_ctrl_if.sv
// Memory-side handshake bundle for the multi-cycle sequencer.
//   instr_req/instr_ack/instr_addr/instr_out : instruction memory req/ack read port
//   data_req/data_we/data_ack/data_out       : data memory req/ack port (address comes from datapath)
// master: sequencer side, slave: memory side.
interface cpu_multicycle_ctrl_if #(
    parameter int unsigned AddrWidth = 32
);
    logic                 instr_req;
    logic                 instr_ack;
    logic [AddrWidth-1:0] instr_addr;
    logic [31:0]          instr_out;
    logic                 data_req;
    logic                 data_we;
    logic                 data_ack;
    logic [31:0]          data_out;

    modport master (
        output instr_req, instr_addr, data_req, data_we,
        input  instr_ack, instr_out, data_ack, data_out
    );

    modport slave (
        input  instr_req, instr_addr, data_req, data_we,
        output instr_ack, instr_out, data_ack, data_out
    );
endinterface

// File: rtl/cpu_multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I core: FETCH/DECODE/EXEC/MEM/WB with req/ack handshakes
// to variable-latency instruction and data memories, plus retire counting, bus timeout and
// misaligned-jump trapping.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   bus               memory handshakes (master modport)
//   ir                latched instruction word
//   dec_is_load/store decoded memory access kind
//   dec_wb_en         decoded register write enable
//   jump_flag/addr    EXE redirect and target
//   load_data         latched load data
//   reg_write_enable  one-cycle register write strobe
//   pc                current instruction address
//   retire_cnt        retired instruction count (wrapping)
//   bus_err/err_code  sticky trap flag and cause (01 IM timeout, 10 DM timeout, 11 misaligned)
module cpu_multicycle_ctrl #(
    parameter int unsigned          AddrWidth = 32,
    parameter logic [AddrWidth-1:0] RESET_PC  = '0,
    parameter int unsigned          TIMEOUT   = 16,
    parameter int unsigned          CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_multicycle_ctrl_if.master bus,
    output logic [31:0]          ir,
    input  logic                 dec_is_load,
    input  logic                 dec_is_store,
    input  logic                 dec_wb_en,
    input  logic                 jump_flag,
    input  logic [AddrWidth-1:0] jump_addr,
    output logic [31:0]          load_data,
    output logic                 reg_write_enable,
    output logic [AddrWidth-1:0] pc,
    output logic [CNT_W-1:0]     retire_cnt,
    output logic                 bus_err,
    output logic [1:0]           err_code
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StError} state_e;

    // The counter only needs to reach TIMEOUT-1; the expiring cycle traps instead of counting.
    localparam int unsigned ToW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] pc_q, pc_d, npc_q, npc_d;
    logic [31:0]          ir_q, ir_d, load_data_q, load_data_d;
    logic [CNT_W-1:0]     retire_q, retire_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [ToW-1:0]       to_cnt_q, to_cnt_d;
    logic                 to_expire;

    // True on the TIMEOUT-th consecutive req cycle; never true when the timeout is disabled.
    assign to_expire = (TIMEOUT != 0) && (32'(to_cnt_q) == TIMEOUT - 1);

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        npc_d            = npc_q;
        ir_d             = ir_q;
        load_data_d      = load_data_q;
        retire_d         = retire_q;
        err_code_d       = err_code_q;
        to_cnt_d         = '0;
        bus.instr_req    = 1'b0;
        bus.data_req     = 1'b0;
        bus.data_we      = 1'b0;
        reg_write_enable = 1'b0;

        unique case (state_q)
            StFetch: begin
                // Gated by rst so requests drop the instant reset asserts.
                bus.instr_req = rst;
                if (bus.instr_ack) begin
                    ir_d    = bus.instr_out;
                    state_d = StDecode;
                end else if (to_expire) begin
                    err_code_d = 2'b01;
                    state_d    = StError;
                end else begin
                    to_cnt_d = to_cnt_q + ToW'(1);
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                npc_d = jump_flag ? jump_addr : pc_q + AddrWidth'(4);
                if (jump_flag && (jump_addr[1:0] != 2'b00)) begin
                    err_code_d = 2'b11;
                    state_d    = StError;
                end else if (dec_is_load || dec_is_store) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                bus.data_req = rst;
                bus.data_we  = rst & dec_is_store;
                if (bus.data_ack) begin
                    if (dec_is_load) load_data_d = bus.data_out;
                    state_d = StWb;
                end else if (to_expire) begin
                    err_code_d = 2'b10;
                    state_d    = StError;
                end else begin
                    to_cnt_d = to_cnt_q + ToW'(1);
                end
            end
            StWb: begin
                reg_write_enable = rst & dec_wb_en & ~dec_is_store;
                pc_d             = npc_q;
                retire_d         = retire_q + CNT_W'(1);
                state_d          = StFetch;
            end
            StError: state_d = StError;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            npc_q       <= RESET_PC;
            ir_q        <= '0;
            load_data_q <= '0;
            retire_q    <= '0;
            err_code_q  <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            ir_q        <= ir_d;
            load_data_q <= load_data_d;
            retire_q    <= retire_d;
            err_code_q  <= err_code_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign bus.instr_addr = pc_q;
    assign pc             = pc_q;
    assign ir             = ir_q;
    assign load_data      = load_data_q;
    assign retire_cnt     = retire_q;
    assign err_code       = err_code_q;
    assign bus_err        = (state_q == StError);

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Bench for cpu_multicycle_ctrl: random instruction stream with a transaction-level model.
module tb_cpu_multicycle_ctrl;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cpu_multicycle_ctrl_if #(.AddrWidth(32)) bus ();
    cpu_multicycle_ctrl_if #(.AddrWidth(32)) bus_nt ();

    logic [31:0] ir, load_data, pc, jump_addr;
    logic        dec_is_load, dec_is_store, dec_wb_en, jump_flag, rwe, bus_err;
    logic [3:0]  retire_cnt;
    logic [1:0]  err_code;

    logic [31:0] nt_ir, nt_load_data, nt_pc, nt_retire;
    logic        nt_rwe, nt_bus_err;
    logic [1:0]  nt_err_code;

    cpu_multicycle_ctrl #(
        .AddrWidth(32), .RESET_PC(32'h0), .TIMEOUT(TO), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.master), .ir(ir),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_wb_en(dec_wb_en),
        .jump_flag(jump_flag), .jump_addr(jump_addr), .load_data(load_data),
        .reg_write_enable(rwe), .pc(pc), .retire_cnt(retire_cnt),
        .bus_err(bus_err), .err_code(err_code)
    );

    // Timeout disabled; instruction memory never answers.
    cpu_multicycle_ctrl #(
        .AddrWidth(32), .RESET_PC(32'h0), .TIMEOUT(0), .CNT_W(32)
    ) dut_nt (
        .clk(clk), .rst(rst), .bus(bus_nt.master), .ir(nt_ir),
        .dec_is_load(1'b0), .dec_is_store(1'b0), .dec_wb_en(1'b0),
        .jump_flag(1'b0), .jump_addr(32'h0), .load_data(nt_load_data),
        .reg_write_enable(nt_rwe), .pc(nt_pc), .retire_cnt(nt_retire),
        .bus_err(nt_bus_err), .err_code(nt_err_code)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: architectural view only.
    logic [31:0] m_pc;
    int unsigned m_retire;
    logic [31:0] m_load;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.instr_ack = 1'b0;
        bus.data_ack  = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("rst_instr_req", 32'(bus.instr_req), 32'h0);
        check_eq("rst_data_req", 32'(bus.data_req), 32'h0);
        check_eq("rst_rwe", 32'(rwe), 32'h0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_ir", ir, 32'h0);
        check_eq("rst_load_data", load_data, 32'h0);
        check_eq("rst_retire", 32'(retire_cnt), 32'h0);
        check_eq("rst_bus_err", 32'(bus_err), 32'h0);
        check_eq("rst_err_code", 32'(err_code), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_pc     = 32'h0;
        m_retire = 0;
        m_load   = 32'h0;
    endtask

    // Trap reached: outputs quiet, cause held, nothing retires even with acks present.
    task automatic check_trap(input logic [1:0] code);
        check_eq("trap_bus_err", 32'(bus_err), 32'h1);
        check_eq("trap_err_code", 32'(err_code), 32'(code));
        check_eq("trap_instr_req", 32'(bus.instr_req), 32'h0);
        check_eq("trap_data_req", 32'(bus.data_req), 32'h0);
        bus.instr_ack = 1'b1;
        bus.data_ack  = 1'b1;
        repeat (3) step();
        bus.instr_ack = 1'b0;
        bus.data_ack  = 1'b0;
        check_eq("trap_hold_err", 32'(bus_err), 32'h1);
        check_eq("trap_hold_code", 32'(err_code), 32'(code));
        check_eq("trap_retire_frozen", 32'(retire_cnt), m_retire);
        check_eq("trap_pc_frozen", pc, m_pc);
        check_eq("trap_rwe", 32'(rwe), 32'h0);
    endtask

    // kind: 0 ALU, 1 load, 2 store, 3 jump, 4 jump (target used as given).
    // A wait >= TO means the memory never answers in time.
    task automatic run_instr(input int kind, input int im_wait, input int dm_wait,
                             input logic [31:0] target, input bit wb, output bit trapped);
        logic [31:0] word, dword, exp_npc;
        bit is_ld, is_st, jmp;
        word  = $urandom;
        dword = $urandom;
        is_ld = (kind == 1);
        is_st = (kind == 2);
        jmp   = (kind >= 3);
        trapped = 1'b0;
        dec_is_load  = is_ld;
        dec_is_store = is_st;
        dec_wb_en    = wb;
        jump_flag    = jmp;
        jump_addr    = jmp ? target : $urandom;
        exp_npc      = jmp ? target : m_pc + 32'd4;

        for (int k = 0; k <= im_wait; k++) begin
            if (k == int'(TO)) begin
                check_trap(2'b01);
                trapped = 1'b1;
                return;
            end
            check_eq("fetch_req", 32'(bus.instr_req), 32'h1);
            check_eq("fetch_addr", bus.instr_addr, m_pc);
            check_eq("fetch_no_dreq", 32'(bus.data_req), 32'h0);
            bus.instr_ack = (k == im_wait);
            bus.instr_out = word;
            bus.data_ack  = 1'($urandom_range(0, 1));
            step();
        end
        bus.instr_ack = 1'($urandom_range(0, 1));
        bus.data_ack  = 1'($urandom_range(0, 1));
        check_eq("decode_ir", ir, word);
        check_eq("decode_no_req", 32'(bus.instr_req), 32'h0);
        check_eq("decode_rwe", 32'(rwe), 32'h0);
        step();
        bus.instr_ack = 1'($urandom_range(0, 1));
        bus.data_ack  = 1'($urandom_range(0, 1));
        check_eq("exec_ir", ir, word);
        check_eq("exec_no_dreq", 32'(bus.data_req), 32'h0);
        check_eq("exec_rwe", 32'(rwe), 32'h0);
        step();
        bus.instr_ack = 1'b0;
        bus.data_ack  = 1'b0;
        if (jmp && (target[1:0] != 2'b00)) begin
            check_trap(2'b11);
            trapped = 1'b1;
            return;
        end
        if (is_ld || is_st) begin
            for (int k = 0; k <= dm_wait; k++) begin
                if (k == int'(TO)) begin
                    check_trap(2'b10);
                    trapped = 1'b1;
                    return;
                end
                check_eq("mem_req", 32'(bus.data_req), 32'h1);
                check_eq("mem_we", 32'(bus.data_we), 32'(is_st));
                check_eq("mem_no_ireq", 32'(bus.instr_req), 32'h0);
                bus.data_ack  = (k == dm_wait);
                bus.data_out  = dword;
                bus.instr_ack = 1'($urandom_range(0, 1));
                step();
            end
            bus.data_ack  = 1'b0;
            bus.instr_ack = 1'b0;
            if (is_ld) m_load = dword;
        end
        check_eq("wb_rwe", 32'(rwe), 32'(wb && !is_st));
        check_eq("wb_load_data", load_data, m_load);
        check_eq("wb_pc_old", pc, m_pc);
        step();
        m_pc     = exp_npc;
        m_retire = (m_retire + 1) % 16;
        check_eq("retire_pc", pc, m_pc);
        check_eq("retire_cnt", 32'(retire_cnt), m_retire);
        check_eq("retire_rwe_drop", 32'(rwe), 32'h0);
        check_eq("retire_load_data", load_data, m_load);
    endtask

    initial begin
        bit tr;
        int kind;
        logic [31:0] tgt;
        bus.instr_ack = 1'b0;  bus.instr_out = 32'h0;
        bus.data_ack  = 1'b0;  bus.data_out  = 32'h0;
        bus_nt.instr_ack = 1'b0; bus_nt.instr_out = 32'h0;
        bus_nt.data_ack  = 1'b0; bus_nt.data_out  = 32'h0;
        dec_is_load = 1'b0; dec_is_store = 1'b0; dec_wb_en = 1'b0;
        jump_flag = 1'b0; jump_addr = 32'h0;

        do_reset();
        run_instr(0, 0, 0, 32'h0, 1'b1, tr);      // zero-wait addi
        run_instr(0, 3, 0, 32'h0, 1'b1, tr);      // IM ack delayed 3
        run_instr(1, 0, 2, 32'h0, 1'b1, tr);      // lw, DM ack delayed 2
        run_instr(2, 1, 0, 32'h0, 1'b1, tr);      // sw with wb_en set: no write
        run_instr(3, 0, 0, 32'h100, 1'b1, tr);    // jal 0x100
        run_instr(0, 0, 0, 32'h0, 1'b0, tr);      // fetch at 0x100
        run_instr(4, 0, 0, 32'h102, 1'b1, tr);    // jalr misaligned
        do_reset();
        run_instr(0, 10, 0, 32'h0, 1'b1, tr);     // IM timeout
        do_reset();
        run_instr(1, 0, 10, 32'h0, 1'b1, tr);     // DM timeout
        do_reset();
        run_instr(1, 3, 3, 32'h0, 1'b1, tr);      // acks on the last allowed cycle

        for (int i = 0; i < 16; i++) run_instr(0, 0, 0, 32'h0, 1'b1, tr);
        check_eq("retire_wrap", 32'(retire_cnt), 32'(m_retire));

        for (int i = 0; i < 80; i++) begin
            kind = (($urandom_range(0, 19) == 0) ? 4 : int'($urandom_range(0, 3)));
            tgt  = $urandom & 32'hFFFF_FFFC;
            if (kind == 4) tgt[1:0] = 2'($urandom_range(1, 3));
            run_instr(kind, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), tgt,
                      1'($urandom_range(0, 1)), tr);
            if (tr) do_reset();
        end

        // Reset pulse in the middle of a load with a late data ack.
        run_instr(0, 0, 0, 32'h0, 1'b1, tr);
        dec_is_load = 1'b1; dec_is_store = 1'b0; dec_wb_en = 1'b1; jump_flag = 1'b0;
        bus.instr_out = $urandom;
        bus.instr_ack = 1'b1;
        step();
        bus.instr_ack = 1'b0;
        step();
        step();
        check_eq("midmem_req", 32'(bus.data_req), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_data_req", 32'(bus.data_req), 32'h0);
        check_eq("async_pc", pc, 32'h0);
        check_eq("async_retire", 32'(retire_cnt), 32'h0);
        check_eq("async_ir", ir, 32'h0);
        bus.data_out = 32'hDEAD_BEEF;
        bus.data_ack = 1'b1;
        step();
        check_eq("late_ack_load", load_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_pc = 32'h0; m_retire = 0; m_load = 32'h0;
        check_eq("restart_addr", bus.instr_addr, 32'h0);
        run_instr(0, 0, 0, 32'h0, 1'b1, tr);
        check_eq("after_late_ack_load", load_data, 32'h0);

        // Timeout disabled: the second controller keeps requesting indefinitely.
        do_reset();
        repeat (1000) step();
        check_eq("nt_instr_req", 32'(bus_nt.instr_req), 32'h1);
        check_eq("nt_bus_err", 32'(nt_bus_err), 32'h0);
        check_eq("nt_err_code", 32'(nt_err_code), 32'h0);
        check_eq("to_trap_main", 32'(err_code), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
